regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
Shares the single write port of the 32x32 RegFile between two writeback requesters: the execute/ALU path (req0) and the load/store unit (req1).
- Grants one write per cycle under a valid/ready handshake.
- Registers the winning write onto the RegFile we/write_addr/din pins.
- Suppresses writes to x0.
- Prevents ALU starvation with an age counter.
Sits between the execute/LSU writeback stages and RegFile in the RV32IC core.

Parameters:
XLEN, 32, data width of register values
AW, 5, register address width
STARVE_LIMIT, 4, consecutive denied cycles of req0 before req0 is forced to win

Ports:
clk  input  1  core clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
req0_valid  input  1  ALU writeback request
req0_addr  input  AW  ALU destination register
req0_data  input  XLEN  ALU result
req0_ready  output  1  ALU request accepted this cycle
req1_valid  input  1  LSU writeback request
req1_addr  input  AW  LSU destination register
req1_data  input  XLEN  load data
req1_ready  output  1  LSU request accepted this cycle
we  output  1  RegFile write enable (registered)
write_addr  output  AW  RegFile write address (registered)
din  output  XLEN  RegFile write data (registered)
starve_cnt  output  3  current req0 denial count (debug/visibility)

Behaviour:
- Reset: synchronous, sampled on the clk rising edge when rst_n=0.
  - we=0, write_addr=0, din=0, starve_cnt=0.
  - ready outputs are combinational and stay 0 while rst_n=0.
- Priority:
  - Default: req1 (LSU) beats req0.
  - Override: if starve_cnt==STARVE_LIMIT, req0 beats req1.
- Grant (combinational, same cycle):
  - Only one valid: that requester's ready=1.
  - Both valid: winner ready=1, loser ready=0.
  - Neither valid: both ready=0.
- Handshake: a transfer occurs when valid&ready. Requesters hold addr/data stable while valid&!ready.
- Latency: a transfer in cycle N drives we/write_addr/din during cycle N+1, and RegFile commits at the end of N+1. No transfer: we=0 next cycle; write_addr/din hold their last value.
- x0: a transfer with addr==0 is accepted (ready=1) but produces we=0 in N+1.
- starve_cnt:
  - Increments when req0_valid & !req0_ready.
  - Clears to 0 on any req0 transfer.
  - Holds when req0_valid=0.
  - Saturates at STARVE_LIMIT; never wraps.
- Same address from both requesters in one cycle: only the winner writes. The loser retries later, so the later write wins (program order is the requesters' responsibility).
- Reset mid-operation: a pending registered write is dropped (we=0 next cycle); no partial writes.
- No internal buffering beyond the one output register; throughput is one write per cycle.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined: adds ports
  - rf_dout0, rf_dout1 input XLEN (from RegFile dout0/dout1)
  - read_addr0, read_addr1 input AW
  - rdata0, rdata1 output XLEN
- Bypass rule: if we=1 and write_addr==read_addrK and read_addrK!=0, then rdata K = din; otherwise rdata K = rf_doutK.
- Forwarding is combinational, so a read issued in the same cycle as the registered write sees the new value.
- Not defined: ports absent; consumers read RegFile dout0/dout1 directly and must stall one cycle on the hazard.

Decomposition:
- Shared package rv32_pkg:
  - XLEN and AW constants.
  - typedef wb_req_t {logic valid; logic [AW-1:0] addr; logic [XLEN-1:0] data;}.
  - REG_ZERO constant (5'd0).
- Natural sub-module: wb_prio_sel, the combinational two-way fixed/override priority selector. Inputs: both valids, the force_req0 flag. Outputs: grant0, grant1.
- The starve counter, output register and bypass logic stay in the top module.

Test Plan:
- Reset: rst_n=0 for 2 cycles with both valid=1 -> ready0=ready1=0, we=0, starve_cnt=0; release -> req1 granted first cycle.
- Single requester: req0 addr=5 data=32'hDEADBEEF, req1 idle -> req0_ready=1 in cycle N; cycle N+1 we=1, write_addr=5, din=32'hDEADBEEF; a RegFile read of r5 at N+2 returns DEADBEEF.
- Contention and starvation: both valid continuously, req1 new data each cycle, STARVE_LIMIT=4 -> req1 wins 4 cycles, starve_cnt reaches 4, req0 wins cycle 5, starve_cnt returns to 0.
- x0 suppression: req1 addr=0 data=32'h1234 -> req1_ready=1, we=0 next cycle; r0 reads 0.
- Reset mid-write: transfer in cycle N, rst_n=0 sampled at end of N -> we=0 in N+1, target register unchanged.
- REGFILE_BYPASS_EN: write r7=32'hCAFEF00D with read_addr0=7 during the write cycle -> rdata0=32'hCAFEF00D while rf_dout0 still shows the old value; read_addr1=0 with write_addr=0 forced -> rdata1=rf_dout1.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32 core types: register-value/address widths and the writeback request bundle.
package rv32_pkg;
   localparam int XLEN = 32;
   localparam int AW   = 5;

   localparam logic [AW-1:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic            valid;
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] data;
   } wb_req_t;
endpackage

// File: rtl/wb_prio_sel.sv
// Two-way writeback priority select, combinational (0 cycles): req1 wins by default, req0 wins when forced.
// The loser sees grant=0 and holds its request until it is granted.
module wb_prio_sel (
   input  logic valid0,
   input  logic valid1,
   input  logic force_req0,
   output logic grant0,
   output logic grant1
);
   always_comb begin
      grant1 = valid1 & ~(force_req0 & valid0);
      grant0 = valid0 & ~grant1;
   end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// RegFile write-port arbiter (ALU vs LSU): grant same cycle, registered write 1 cycle later, x0 writes dropped.
// Loser is held off via ready=0; an age counter forces ALU priority. REGFILE_BYPASS_EN adds read forwarding.
module regfile_wb_arbiter
   import rv32_pkg::*;
#(
   parameter int XLEN_P       = XLEN,
   parameter int AW_P         = AW,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   input  logic [AW_P-1:0]   req0_addr,
   input  logic [XLEN_P-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [AW_P-1:0]   req1_addr,
   input  logic [XLEN_P-1:0] req1_data,
   output logic              req1_ready,
   output logic              we,
   output logic [AW_P-1:0]   write_addr,
   output logic [XLEN_P-1:0] din,
`ifdef REGFILE_BYPASS_EN
   input  logic [XLEN_P-1:0] rf_dout0,
   input  logic [XLEN_P-1:0] rf_dout1,
   input  logic [AW_P-1:0]   read_addr0,
   input  logic [AW_P-1:0]   read_addr1,
   output logic [XLEN_P-1:0] rdata0,
   output logic [XLEN_P-1:0] rdata1,
`endif
   output logic [2:0]        starve_cnt
);
   wb_req_t req0, req1, win;
   logic    grant0, grant1, force_req0;

   assign req0 = '{valid: req0_valid, addr: req0_addr, data: req0_data};
   assign req1 = '{valid: req1_valid, addr: req1_addr, data: req1_data};

   assign force_req0 = (starve_cnt == 3'(STARVE_LIMIT));

   wb_prio_sel u_prio_sel (
      .valid0     (req0_valid),
      .valid1     (req1_valid),
      .force_req0 (force_req0),
      .grant0     (grant0),
      .grant1     (grant1)
   );

   // Nothing may be accepted while reset is asserted, otherwise a request would be lost.
   assign req0_ready = grant0 & rst_n;
   assign req1_ready = grant1 & rst_n;

   always_comb begin
      win = '0;
      if (req0_ready)
         win = req0;
      else if (req1_ready)
         win = req1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         we         <= 1'b0;
         write_addr <= '0;
         din        <= '0;
         starve_cnt <= 3'd0;
      end else begin
         we <= 1'b0;
         if (win.valid) begin
            we         <= (win.addr != REG_ZERO);
            write_addr <= win.addr;
            din        <= win.data;
         end
         if (req0_ready)
            starve_cnt <= 3'd0;
         else if (req0_valid && !force_req0)
            starve_cnt <= starve_cnt + 3'd1;
      end
   end

`ifdef REGFILE_BYPASS_EN
   assign rdata0 = (we && write_addr == read_addr0 && read_addr0 != REG_ZERO) ? din : rf_dout0;
   assign rdata1 = (we && write_addr == read_addr1 && read_addr1 != REG_ZERO) ? din : rf_dout1;
`endif
endmodule
